// File: rtl/gbd_ram_writer.sv
// gbd_ram_writer: streams bytes into cartridge save SRAM through the mapper override port.
// Rev 1.0 - initial release.
`default_nettype none

module gbd_ram_writer #(
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic        sys_clock,
  input  logic        sys_reset,
  input  logic        start,
  input  logic [11:0] start_addr,
  input  logic [12:0] byte_count,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        is_gbd_writing_ram,
  output logic [7:0]  out_Writing_dq,
  output logic [11:0] out_Writing_Addr_low,
  output logic        out_Writing_nCS,
  output logic        out_Writing_nWE,
  output logic        busy,
  output logic        done,
  output logic        aborted
);

  localparam int C_MAX_SP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int C_MAX    = (C_MAX_SP > HOLD_CYCLES) ? C_MAX_SP : HOLD_CYCLES;
  localparam int CNT_W    = (C_MAX > 1) ? $clog2(C_MAX) : 1;

  localparam logic [CNT_W-1:0] C_SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [12:0]      C_MAX_BYTES  = 13'd4096;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ACQUIRE   = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_SETUP     = 3'd3,
    S_PULSE     = 3'd4,
    S_HOLD      = 3'd5,
    S_RELEASE   = 3'd6
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [11:0]      addr_q;
  logic [12:0]      remaining_q;
  logic             abort_seen_q;
  logic             in_ready_q;
  logic             gbd_q;
  logic [7:0]       dq_q;
  logic [11:0]      addr_out_q;
  logic             ncs_q;
  logic             nwe_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;

  logic [12:0]      count_clamped_d;
  logic             accept_d;
  logic             abort_any_d;

  assign count_clamped_d = (byte_count > C_MAX_BYTES) ? C_MAX_BYTES : byte_count;
  assign abort_any_d     = abort | abort_seen_q;
  // A pending abort withdraws ready in the same cycle so the presented byte is left untouched.
  assign in_ready        = in_ready_q & ~abort_any_d;
  assign accept_d        = in_valid & in_ready;

  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      remaining_q  <= '0;
      abort_seen_q <= 1'b0;
      in_ready_q   <= 1'b0;
      gbd_q        <= 1'b0;
      dq_q         <= '0;
      addr_out_q   <= '0;
      ncs_q        <= 1'b1;
      nwe_q        <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy_q && abort) begin
        abort_seen_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (byte_count == 13'd0) begin
              done_q    <= 1'b1;
              aborted_q <= 1'b0;
            end else begin
              addr_q       <= start_addr;
              remaining_q  <= count_clamped_d;
              abort_seen_q <= 1'b0;
              gbd_q        <= 1'b1;
              busy_q       <= 1'b1;
              state_q      <= S_ACQUIRE;
            end
          end
        end

        S_ACQUIRE: begin
          in_ready_q <= 1'b1;
          state_q    <= S_WAIT_DATA;
        end

        S_WAIT_DATA: begin
          if (abort_any_d) begin
            in_ready_q <= 1'b0;
            gbd_q      <= 1'b0;
            done_q     <= 1'b1;
            aborted_q  <= 1'b1;
            state_q    <= S_RELEASE;
          end else if (accept_d) begin
            in_ready_q <= 1'b0;
            dq_q       <= in_data;
            addr_out_q <= addr_q;
            ncs_q      <= 1'b0;
            cnt_q      <= '0;
            state_q    <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (cnt_q == C_SETUP_LAST) begin
            cnt_q   <= '0;
            nwe_q   <= 1'b0;
            state_q <= S_PULSE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_PULSE: begin
          // nWE and nCS rise on the same edge; abort never shortens the strobe.
          if (cnt_q == C_PULSE_LAST) begin
            cnt_q   <= '0;
            nwe_q   <= 1'b1;
            ncs_q   <= 1'b1;
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_HOLD: begin
          if (cnt_q == C_HOLD_LAST) begin
            cnt_q       <= '0;
            remaining_q <= remaining_q - 13'd1;
            addr_q      <= addr_q + 12'd1;
            if ((remaining_q == 13'd1) || abort_any_d) begin
              gbd_q     <= 1'b0;
              done_q    <= 1'b1;
              aborted_q <= (remaining_q != 13'd1);
              state_q   <= S_RELEASE;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= S_WAIT_DATA;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_RELEASE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          gbd_q      <= 1'b0;
          ncs_q      <= 1'b1;
          nwe_q      <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign is_gbd_writing_ram   = gbd_q;
  assign out_Writing_dq       = dq_q;
  assign out_Writing_Addr_low = addr_out_q;
  assign out_Writing_nCS      = ncs_q;
  assign out_Writing_nWE      = nwe_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign aborted              = aborted_q;

endmodule

`default_nettype wire
